mcu_spi_link: RTL

//  SPI slave to the IO MCU. Turns MCU SPI frames into the byte stream that feeds the hid block.
//  - Byte stream outputs: data_in_strobe, data_in_start, data_in.
//  - MISO path: returns hid data_out to the MCU.
//  - Frame = CSn low period. The first byte of each frame is the command byte.
//  - All logic runs in the system clock domain. SPI pins are oversampled; SCLK is not a clock.

---
 rtl/mcu_spi_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 31 +++
 rtl/mcu_spi_link.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI slave link and the hid block behind it:
// byte width, link FSM states and the command codes carried in the first byte of a frame.
package mcu_spi_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } spi_state_e;

    localparam logic [WIDTH-1:0] CMD_STATUS   = 8'd0;
    localparam logic [WIDTH-1:0] CMD_KEYBOARD = 8'd1;
    localparam logic [WIDTH-1:0] CMD_MOUSE    = 8'd2;
    localparam logic [WIDTH-1:0] CMD_JOYSTICK = 8'd3;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
        return {v[WIDTH-2:0], b};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for one oversampled SPI pin, with edge detection on the synchronised value.
// Flops clear to 0 so a reset released while CSn is low looks like an active frame.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/mcu_spi_link.sv
// SPI mode-0 slave to the IO MCU, oversampled in the system clock domain.
// Received bytes stream to hid; hid's reply to byte N is shifted out on byte N+1.
module mcu_spi_link
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spi_csn,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             data_in_strobe,
    output logic             data_in_start,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic             frame_active,
    output spi_state_e       o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    // Asynchronous assert, synchronous release.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic w_csn_sync, w_csn_rise, w_csn_fall;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_pin(spi_csn),
        .o_sync(w_csn_sync), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_pin(spi_sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_pin(spi_mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_edges = w_csn_rise ^ w_sclk_sync ^ w_mosi_rise ^ w_mosi_fall;

    spi_state_e       r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_data_in;
    logic             r_strobe;
    logic             r_start;
    logic             r_first;
    logic             r_load_d1;
    logic             r_skip_fall;
    logic [CNT_W-1:0] w_cnt_base;

    // A completed byte and the first bit of the next one may land on the same clk.
    assign w_cnt_base = (r_bit_cnt == CNT_FULL) ? '0 : r_bit_cnt;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= WAIT_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_data_in   <= '0;
            r_strobe    <= 1'b0;
            r_start     <= 1'b0;
            r_first     <= 1'b0;
            r_load_d1   <= 1'b0;
            r_skip_fall <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            r_start   <= 1'b0;
            r_load_d1 <= r_strobe;
            case (r_state)
                WAIT_IDLE: begin
                    if (w_csn_sync) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_csn_fall) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_first     <= 1'b1;
                        r_tx_shift  <= '0;
                        r_skip_fall <= 1'b0;
                        r_load_d1   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_csn_sync) begin
                        r_state    <= IDLE;
                        r_bit_cnt  <= '0;
                        r_tx_shift <= '0;
                        r_load_d1  <= 1'b0;
                    end else begin
                        if (r_bit_cnt == CNT_FULL) begin
                            r_data_in <= r_rx_shift;
                            r_start   <= r_first;
                            r_strobe  <= 1'b1;
                            r_first   <= 1'b0;
                        end
                        if (w_sclk_rise) begin
                            r_rx_shift <= shift_in(r_rx_shift, w_mosi_sync);
                            r_bit_cnt  <= w_cnt_base + 1'b1;
                        end else if (r_bit_cnt == CNT_FULL) begin
                            r_bit_cnt <= '0;
                        end
                        // A fall coinciding with the load is the trailing edge itself.
                        if (r_load_d1) begin
                            r_tx_shift  <= data_out;
                            r_skip_fall <= ~w_sclk_fall;
                        end else if (w_sclk_fall) begin
                            if (r_skip_fall) begin
                                r_skip_fall <= 1'b0;
                            end else begin
                                r_tx_shift <= shift_in(r_tx_shift, 1'b0);
                            end
                        end
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

    assign spi_miso       = r_tx_shift[WIDTH-1];
    assign data_in_strobe = r_strobe;
    assign data_in_start  = r_start;
    assign data_in        = r_data_in;
    assign frame_active   = (r_state == SHIFT);
    assign o_dbg_state    = r_state;

endmodule
